// File: rtl/gray_sync_pkg.sv
// gray_sync_pkg: shared types, limits and helper functions for the Gray-count
// synchroniser/decoder.
package gray_sync_pkg;

   localparam int MIN_SYNC_STAGES = 2;
   localparam int MAX_SYNC_STAGES = 4;
   localparam int MAX_WIDTH       = 32;

   typedef enum logic {
      S_FILL,
      S_RUN
   } fsm_state_t;

   // Bits at or above 'width' are treated as zero, so any bus up to MAX_WIDTH can use this.
   function automatic logic [MAX_WIDTH-1:0] gray2bin(input logic [MAX_WIDTH-1:0] g,
                                                     input int                   width);
      logic [MAX_WIDTH:0] b;
      b = '0;
      for (int i = MAX_WIDTH - 1; i >= 0; i--) begin
         b[i] = (i < width) ? (g[i] ^ b[i+1]) : 1'b0;
      end
      return b[MAX_WIDTH-1:0];
   endfunction

   function automatic int popcount(input logic [MAX_WIDTH-1:0] v);
      int cnt;
      cnt = 0;
      for (int i = 0; i < MAX_WIDTH; i++) begin
         cnt += int'(v[i]);
      end
      return cnt;
   endfunction

endpackage

// File: rtl/gray_sync_decoder_gray_to_binary.sv
// gray_to_binary: purely combinational Gray-to-binary converter; each binary bit is
// the XOR of all Gray bits at or above it.
module gray_to_binary
   import gray_sync_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic [WIDTH-1:0] gray,
   output logic [WIDTH-1:0] bin
);

   // Written as independent reductions rather than a ripple on bin itself, so the
   // vector never feeds back into its own assignment.
   for (genvar i = 0; i < WIDTH; i++) begin : g_prefix
      assign bin[i] = ^gray[WIDTH-1:i];
   end

endmodule

// File: rtl/gray_sync_decoder.sv
// gray_sync_decoder: synchronises a foreign-domain Gray count into clk, decodes it to
// binary, reports the per-sample delta and flags multi-bit steps.
// Optional macro GRAY_SYNC_HOLD_ON_ERR_EN: on a multi-bit step only the error flag sets.
module gray_sync_decoder
   import gray_sync_pkg::*;
#(
   parameter int WIDTH       = 4,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] gray_in,
   input  logic             err_clear,
   output logic [WIDTH-1:0] bin_out,
   output logic             bin_valid,
   output logic [WIDTH-1:0] delta,
   output logic             changed,
   output logic             err_multi_bit
);

   localparam int              CNT_W     = $clog2(SYNC_STAGES + 1);
   localparam logic [CNT_W-1:0] FILL_LAST = CNT_W'(SYNC_STAGES);

   if (SYNC_STAGES < MIN_SYNC_STAGES || SYNC_STAGES > MAX_SYNC_STAGES) begin : g_bad_stages
      $error("gray_sync_decoder: SYNC_STAGES must be in 2..4");
   end
   if (WIDTH < 1 || WIDTH > MAX_WIDTH) begin : g_bad_width
      $error("gray_sync_decoder: WIDTH out of range");
   end

   logic [WIDTH-1:0] sync_q [SYNC_STAGES];
   logic [WIDTH-1:0] gray_s;
   logic [WIDTH-1:0] bin_new;
   logic [WIDTH-1:0] bin_step;
   int               hd;

   fsm_state_t       state_q,     state_d;
   logic [CNT_W-1:0] fill_cnt_q,  fill_cnt_d;
   logic [WIDTH-1:0] gray_prev_q, gray_prev_d;
   logic [WIDTH-1:0] bin_q,       bin_d;
   logic             valid_q,     valid_d;
   logic [WIDTH-1:0] delta_q,     delta_d;
   logic             changed_q,   changed_d;
   logic             err_q,       err_d;
   logic             err_set;

   // NOTE: the synchroniser array is reset on purpose: until the chain has been
   // refilled, outputs must be the defined reset values, not leftover samples.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < SYNC_STAGES; i++) begin
            sync_q[i] <= '0;
         end
      end else begin
         sync_q[0] <= gray_in;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_q[i] <= sync_q[i-1];
         end
      end
   end

   assign gray_s = sync_q[SYNC_STAGES-1];

   gray_to_binary #(
      .WIDTH(WIDTH)
   ) u_gray_to_binary (
      .gray(gray_s),
      .bin (bin_new)
   );

   // bin_q always equals the decode of gray_prev_q, so it serves as bin_prev.
   assign bin_step = bin_new - bin_q;

   // NOTE: every variable gets a default before the case so no path leaves one
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      hd          = popcount(MAX_WIDTH'(gray_s ^ gray_prev_q));
      state_d     = state_q;
      fill_cnt_d  = fill_cnt_q;
      gray_prev_d = gray_prev_q;
      bin_d       = bin_q;
      valid_d     = valid_q;
      delta_d     = delta_q;
      changed_d   = 1'b0;
      err_set     = 1'b0;

      case (state_q)
         S_FILL: begin
            if (fill_cnt_q == FILL_LAST) begin
               gray_prev_d = gray_s;
               bin_d       = bin_new;
               valid_d     = 1'b1;
               state_d     = S_RUN;
            end else begin
               fill_cnt_d = fill_cnt_q + 1'b1;
            end
         end
         S_RUN: begin
            if (hd == 1) begin
               changed_d   = 1'b1;
               delta_d     = bin_step;
               bin_d       = bin_new;
               gray_prev_d = gray_s;
            end else if (hd > 1) begin
               err_set = 1'b1;
`ifdef GRAY_SYNC_HOLD_ON_ERR_EN
               // Keep the last good value so the next sample is judged against it.
`else
               changed_d   = 1'b1;
               delta_d     = bin_step;
               bin_d       = bin_new;
               gray_prev_d = gray_s;
`endif
            end
         end
         default: state_d = S_FILL;
      endcase

      // A fresh error outranks a simultaneous clear.
      if (err_set) begin
         err_d = 1'b1;
      end else if (err_clear) begin
         err_d = 1'b0;
      end else begin
         err_d = err_q;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples
   // the pre-edge values, independent of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_FILL;
         fill_cnt_q  <= '0;
         gray_prev_q <= '0;
         bin_q       <= '0;
         valid_q     <= 1'b0;
         delta_q     <= '0;
         changed_q   <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         fill_cnt_q  <= fill_cnt_d;
         gray_prev_q <= gray_prev_d;
         bin_q       <= bin_d;
         valid_q     <= valid_d;
         delta_q     <= delta_d;
         changed_q   <= changed_d;
         err_q       <= err_d;
      end
   end

   assign bin_out       = bin_q;
   assign bin_valid     = valid_q;
   assign delta         = delta_q;
   assign changed       = changed_q;
   assign err_multi_bit = err_q;

endmodule
